// File: rtl/bomb_if.sv
// Bomb scheduler bus: placement requests, chain flames,
// explosion handshake and per-player bomb counts.
interface bomb_if;
  logic       tick;
  logic       p1_set_bomb;
  logic [7:0] p1_coord;
  logic       p2_set_bomb;
  logic [7:0] p2_coord;
  logic [2:0] bomb_max_1;
  logic [2:0] bomb_max_2;
  logic       chain_valid;
  logic [7:0] chain_coord;
  logic       expl_ready;
  logic [2:0] bomb_num_1;
  logic [2:0] bomb_num_2;
  logic       p1_ack;
  logic       p2_ack;
  logic       expl_valid;
  logic [7:0] expl_coord;
  logic       expl_owner;
  logic       full;

  modport master (
    output tick, p1_set_bomb, p1_coord,
    output p2_set_bomb, p2_coord,
    output bomb_max_1, bomb_max_2,
    output chain_valid, chain_coord,
    output expl_ready,
    input  bomb_num_1, bomb_num_2,
    input  p1_ack, p2_ack,
    input  expl_valid, expl_coord, expl_owner,
    input  full
  );

  modport slave (
    input  tick, p1_set_bomb, p1_coord,
    input  p2_set_bomb, p2_coord,
    input  bomb_max_1, bomb_max_2,
    input  chain_valid, chain_coord,
    input  expl_ready,
    output bomb_num_1, bomb_num_2,
    output p1_ack, p2_ack,
    output expl_valid, expl_coord, expl_owner,
    output full
  );
endinterface

// File: rtl/bomb_scheduler.sv
// Bomb slot pool for both players: placement, fuse timers,
// chain reactions and one-at-a-time explosion presentation.
module bomb_scheduler #(
  parameter int         SLOTS = 8,
  parameter logic [3:0] FUSE  = 4'd6
) (
  input logic   clk,
  input logic   rst,
  bomb_if.slave bus
);
  localparam int IW = $clog2(SLOTS);

  typedef enum logic {EX_IDLE, EX_HOLD} ex_e;

  logic [SLOTS-1:0]      act_q, act_d;
  logic [SLOTS-1:0]      own_q, own_d;
  logic [SLOTS-1:0][7:0] crd_q, crd_d;
  logic [SLOTS-1:0][3:0] tmr_q, tmr_d;

  logic       rr_q, rr_d;
  logic       ack1_q, ack1_d;
  logic       ack2_q, ack2_d;
  logic [2:0] num1_q, num1_d;
  logic [2:0] num2_q, num2_d;
  logic       full_q, full_d;

  ex_e           ex_q, ex_d;
  logic [IW-1:0] lock_q, lock_d;

  logic [SLOTS-1:0] exp_w;
  logic             any_exp;
  logic [IW-1:0]    low_idx;
  logic [IW-1:0]    sel_idx;
  logic             fire;
  logic             dec1, dec2;

  logic             hit1, hit2;
  logic             p1_ok, p2_ok;
  logic             both, first2;
  logic             first_ok, second_ok;
  logic             found0, found1;
  logic [IW-1:0]    f0, f1;
  logic [SLOTS-1:0] f0_oh, free_rem;
  logic             acc_first, acc_second;
  logic             acc1, acc2;
  logic [7:0]       first_crd, second_crd;

  function automatic logic [IW:0] pick(
    input logic [SLOTS-1:0] v
  );
    logic [IW:0] r;
    r = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (v[i]) r = {1'b1, IW'(i)};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      exp_w[i] = act_q[i] & (tmr_q[i] == 4'd0);
    end
    {any_exp, low_idx} = pick(exp_w);
  end

  // Presentation FSM: once shown, a slot is held until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q   <= EX_IDLE;
      lock_q <= '0;
    end else begin
      ex_q   <= ex_d;
      lock_q <= lock_d;
    end
  end

  always_comb begin
    ex_d   = ex_q;
    lock_d = lock_q;
    unique case (ex_q)
      EX_IDLE: begin
        if (any_exp && !bus.expl_ready) begin
          ex_d   = EX_HOLD;
          lock_d = low_idx;
        end
      end
      EX_HOLD: begin
        if (bus.expl_ready) ex_d = EX_IDLE;
      end
    endcase
  end

  always_comb begin
    sel_idx = (ex_q == EX_HOLD) ? lock_q : low_idx;
    fire    = any_exp & bus.expl_ready;
    dec1    = fire & ~own_q[sel_idx];
    dec2    = fire & own_q[sel_idx];
  end

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      hit1 = hit1 | (act_q[i] & (crd_q[i] == bus.p1_coord));
      hit2 = hit2 | (act_q[i] & (crd_q[i] == bus.p2_coord));
    end
    p1_ok = bus.p1_set_bomb & (num1_q < bus.bomb_max_1) & ~hit1;
    p2_ok = bus.p2_set_bomb & (num2_q < bus.bomb_max_2) & ~hit2;

    both   = bus.p1_set_bomb & bus.p2_set_bomb;
    first2 = (bus.p2_set_bomb & ~bus.p1_set_bomb) | (both & rr_q);

    first_ok  = first2 ? p2_ok : p1_ok;
    second_ok = both & (first2 ? p1_ok : p2_ok)
              & (bus.p1_coord != bus.p2_coord);

    // Both grants come from start-of-cycle free slots only
    {found0, f0} = pick(~act_q);
    acc_first    = first_ok & found0;
    f0_oh        = '0;
    f0_oh[f0]    = acc_first;
    free_rem     = ~act_q & ~f0_oh;
    {found1, f1} = pick(free_rem);
    acc_second   = second_ok & found1;

    acc1       = first2 ? acc_second : acc_first;
    acc2       = first2 ? acc_first : acc_second;
    first_crd  = first2 ? bus.p2_coord : bus.p1_coord;
    second_crd = first2 ? bus.p1_coord : bus.p2_coord;
  end

  always_comb begin
    act_d = act_q;
    own_d = own_q;
    crd_d = crd_q;
    tmr_d = tmr_q;
    for (int i = 0; i < SLOTS; i++) begin
      if (act_q[i]) begin
        if (bus.chain_valid && crd_q[i] == bus.chain_coord) begin
          tmr_d[i] = 4'd0;
        end else if (bus.tick && tmr_q[i] != 4'd0) begin
          tmr_d[i] = tmr_q[i] - 4'd1;
        end
      end
    end
    if (fire) act_d[sel_idx] = 1'b0;
    if (acc_first) begin
      act_d[f0] = 1'b1;
      own_d[f0] = first2;
      crd_d[f0] = first_crd;
      tmr_d[f0] = FUSE;
    end
    if (acc_second) begin
      act_d[f1] = 1'b1;
      own_d[f1] = ~first2;
      crd_d[f1] = second_crd;
      tmr_d[f1] = FUSE;
    end
  end

  always_comb begin
    num1_d = num1_q + {2'b00, acc1} - {2'b00, dec1};
    num2_d = num2_q + {2'b00, acc2} - {2'b00, dec2};
    full_d = &act_d;
    rr_d   = rr_q ^ both;
    ack1_d = acc1;
    ack2_d = acc2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q  <= '0;
      own_q  <= '0;
      crd_q  <= '0;
      tmr_q  <= '0;
      rr_q   <= 1'b0;
      ack1_q <= 1'b0;
      ack2_q <= 1'b0;
      num1_q <= '0;
      num2_q <= '0;
      full_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      own_q  <= own_d;
      crd_q  <= crd_d;
      tmr_q  <= tmr_d;
      rr_q   <= rr_d;
      ack1_q <= ack1_d;
      ack2_q <= ack2_d;
      num1_q <= num1_d;
      num2_q <= num2_d;
      full_q <= full_d;
    end
  end

  assign bus.bomb_num_1 = num1_q;
  assign bus.bomb_num_2 = num2_q;
  assign bus.p1_ack     = ack1_q;
  assign bus.p2_ack     = ack2_q;
  assign bus.full       = full_q;
  assign bus.expl_valid = any_exp;
  assign bus.expl_coord = any_exp ? crd_q[sel_idx] : 8'h00;
  assign bus.expl_owner = any_exp & own_q[sel_idx];
endmodule
